// File: rtl/motors_cmd_sequencer.sv
// rtl/motors_cmd_sequencer.sv - command FIFO and chunking sequencer driving the motors controller handshake
module motors_cmd_sequencer #(
    parameter int PULSE_NUM_X_BITS = 16,
    parameter int PULSE_NUM_Y_BITS = 16,
    parameter int CMD_BITS         = 24,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clk_en,
    input  logic signed [CMD_BITS-1:0]         cmd_dx,
    input  logic signed [CMD_BITS-1:0]         cmd_dy,
    input  logic                               cmd_pen,
    input  logic                               cmd_valid,
    output logic                               cmd_rdy,
    output logic signed [PULSE_NUM_X_BITS-1:0] pulse_num_x,
    output logic signed [PULSE_NUM_Y_BITS-1:0] pulse_num_y,
    output logic                               servo_pos,
    output logic                               trigger,
    input  logic                               motors_rdy,
    output logic                               busy
);
    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_BITS = 2 * CMD_BITS + 1;

    localparam logic signed [CMD_BITS-1:0] MAXX = CMD_BITS'((1 << (PULSE_NUM_X_BITS - 1)) - 1);
    localparam logic signed [CMD_BITS-1:0] MAXY = CMD_BITS'((1 << (PULSE_NUM_Y_BITS - 1)) - 1);
    localparam logic [PTR_BITS:0]          CNT_ONE  = (PTR_BITS + 1)'(1);
    localparam logic [PTR_BITS:0]          CNT_FULL = (PTR_BITS + 1)'(FIFO_DEPTH);
    localparam logic [PTR_BITS-1:0]        PTR_ONE  = PTR_BITS'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT} state_t;

    state_t                        state_q, state_d;
    logic signed [CMD_BITS-1:0]    rem_x_q, rem_x_d, rem_y_q, rem_y_d;
    logic                          pen_q, pen_d;
    logic signed [PULSE_NUM_X_BITS-1:0] px_q, px_d;
    logic signed [PULSE_NUM_Y_BITS-1:0] py_q, py_d;
    logic                          servo_q, servo_d;
    logic                          trig_q, trig_d;
    logic [PTR_BITS-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]             count_q, count_d;
    logic [ENTRY_BITS-1:0]         mem_q [FIFO_DEPTH];

    logic                          push, pop;
    logic [ENTRY_BITS-1:0]         head;
    logic signed [CMD_BITS-1:0]    cx, cy;

    // Comparison happens at full command width so -2^(CMD_BITS-1) cannot overflow.
    function automatic logic signed [CMD_BITS-1:0] clamp(
        input logic signed [CMD_BITS-1:0] v,
        input logic signed [CMD_BITS-1:0] lim
    );
        if (v > lim) begin
            return lim;
        end else if (v < -lim) begin
            return -lim;
        end
        return v;
    endfunction

    assign cmd_rdy = (count_q != CNT_FULL);
    assign push    = clk_en & cmd_valid & cmd_rdy;
    assign pop     = clk_en & (state_q == S_LOAD);
    assign head    = mem_q[rd_ptr_q];
    assign cx      = clamp(rem_x_q, MAXX);
    assign cy      = clamp(rem_y_q, MAXY);

    always_comb begin
        state_d  = state_q;
        rem_x_d  = rem_x_q;
        rem_y_d  = rem_y_q;
        pen_d    = pen_q;
        px_d     = px_q;
        py_d     = py_q;
        servo_d  = servo_q;
        trig_d   = trig_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (clk_en) begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) state_d = S_LOAD;
                end
                S_LOAD: begin
                    rem_x_d  = head[CMD_BITS-1:0];
                    rem_y_d  = head[2*CMD_BITS-1:CMD_BITS];
                    pen_d    = head[ENTRY_BITS-1];
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    state_d  = S_ISSUE;
                end
                S_ISSUE: begin
                    // First cycle in ISSUE launches the chunk; later cycles wait for rdy to drop.
                    if (!trig_q) begin
                        px_d    = cx[PULSE_NUM_X_BITS-1:0];
                        py_d    = cy[PULSE_NUM_Y_BITS-1:0];
                        servo_d = pen_q;
                        trig_d  = 1'b1;
                        rem_x_d = rem_x_q - cx;
                        rem_y_d = rem_y_q - cy;
                    end else if (!motors_rdy) begin
                        trig_d  = 1'b0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (motors_rdy) begin
                        if (rem_x_q != '0 || rem_y_q != '0) begin
                            state_d = S_ISSUE;
                        end else if (count_q != '0) begin
                            state_d = S_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            rem_x_q  <= '0;
            rem_y_q  <= '0;
            pen_q    <= 1'b0;
            px_q     <= '0;
            py_q     <= '0;
            servo_q  <= 1'b0;
            trig_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rem_x_q  <= rem_x_d;
            rem_y_q  <= rem_y_d;
            pen_q    <= pen_d;
            px_q     <= px_d;
            py_q     <= py_d;
            servo_q  <= servo_d;
            trig_q   <= trig_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_pen, cmd_dy, cmd_dx};
        end
    end

    assign pulse_num_x = px_q;
    assign pulse_num_y = py_q;
    assign servo_pos   = servo_q;
    assign trigger     = trig_q;
    assign busy        = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_motors_cmd_sequencer.sv
// tb/tb_motors_cmd_sequencer.sv - directed bench for motors_cmd_sequencer with a motors controller model
module tb_motors_cmd_sequencer;
    localparam int PXB = 4;
    localparam int PYB = 4;
    localparam int CB  = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  clk_en = 1'b1;
    logic signed [CB-1:0]  cmd_dx = '0;
    logic signed [CB-1:0]  cmd_dy = '0;
    logic                  cmd_pen = 1'b0;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_rdy;
    logic signed [PXB-1:0] pulse_num_x;
    logic signed [PYB-1:0] pulse_num_y;
    logic                  servo_pos;
    logic                  trigger;
    logic                  motors_rdy = 1'b1;
    logic                  busy;

    int n_vec = 0;
    int n_err = 0;
    bit stall = 0;
    bit gate = 0;
    int low_cnt = 0;
    bit pend = 0;
    bit trig_prev = 0;
    bit rdy_prev = 1;
    bit armed = 1;
    int viol = 0;
    int qx[$];
    int qy[$];
    int qp[$];

    motors_cmd_sequencer #(
        .PULSE_NUM_X_BITS(PXB),
        .PULSE_NUM_Y_BITS(PYB),
        .CMD_BITS(CB),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_en(clk_en),
        .cmd_dx(cmd_dx),
        .cmd_dy(cmd_dy),
        .cmd_pen(cmd_pen),
        .cmd_valid(cmd_valid),
        .cmd_rdy(cmd_rdy),
        .pulse_num_x(pulse_num_x),
        .pulse_num_y(pulse_num_y),
        .servo_pos(servo_pos),
        .trigger(trigger),
        .motors_rdy(motors_rdy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Motors controller: rdy drops one cycle after trigger, rises 5 cycles later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall) begin
                motors_rdy = 1'b0;
                pend = 0;
                low_cnt = 0;
            end else if (pend) begin
                motors_rdy = 1'b0;
                low_cnt = 5;
                pend = 0;
            end else if (low_cnt != 0) begin
                low_cnt--;
                if (low_cnt == 0) motors_rdy = 1'b1;
            end else begin
                motors_rdy = 1'b1;
                if (trigger) pend = 1;
            end
            if (trigger && !trig_prev) begin
                if (!armed) viol++;
                armed = 0;
                qx.push_back(int'(pulse_num_x));
                qy.push_back(int'(pulse_num_y));
                qp.push_back(int'(servo_pos));
            end
            if (motors_rdy && !rdy_prev) armed = 1;
            trig_prev = trigger;
            rdy_prev = motors_rdy;
        end
    end

    initial begin
        int g = 0;
        forever begin
            @(posedge clk);
            #1;
            if (gate) begin
                clk_en = (g % 3 == 0);
                g++;
            end else begin
                clk_en = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int dx, input int dy, input bit pen);
        bit acc = 0;
        int n = 0;
        cmd_dx = CB'(dx);
        cmd_dy = CB'(dy);
        cmd_pen = pen;
        cmd_valid = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = cmd_rdy && clk_en;
            @(posedge clk);
            #1;
            n++;
        end
        cmd_valid = 1'b0;
        if (!acc) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, int'(busy), 0);
    endtask

    task automatic chk_chunk(input string tag, input int i, input int x, input int y, input int p);
        if (i < qx.size()) begin
            chk({tag, "_x"}, qx[i], x);
            chk({tag, "_y"}, qy[i], y);
            chk({tag, "_pen"}, qp[i], p);
        end else begin
            chk({tag, "_missing"}, i, qx.size() - 1);
        end
    endtask

    task automatic qclear();
        qx.delete();
        qy.delete();
        qp.delete();
    endtask

    initial begin
        int n;
        int sx;
        int sy;
        int bad;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_px", int'(pulse_num_x), 0);
        chk("rst_py", int'(pulse_num_y), 0);
        chk("rst_trigger", int'(trigger), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_servo", int'(servo_pos), 0);
        chk("rst_cmd_rdy", int'(cmd_rdy), 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Chunking and accept-to-trigger latency
        qclear();
        push(20, -3, 1);
        n = 0;
        while (!trigger && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("s1_latency", n, 3);
        wait_idle("s1_idle", 200);
        chk("s1_count", qx.size(), 3);
        chk_chunk("s1_c0", 0, 7, -3, 1);
        chk_chunk("s1_c1", 1, 7, 0, 1);
        chk_chunk("s1_c2", 2, 6, 0, 1);

        // Pen-only move
        qclear();
        push(0, 0, 0);
        wait_idle("s2_idle", 100);
        chk("s2_count", qx.size(), 1);
        chk_chunk("s2_c0", 0, 0, 0, 0);
        chk("s2_servo_hold", int'(servo_pos), 0);

        // Back-pressure with stalled controller
        qclear();
        stall = 1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        push(1, 1, 1);
        push(2, -2, 0);
        push(3, 3, 1);
        push(-4, 4, 0);
        chk("s3_rdy_before_5th", int'(cmd_rdy), 1);
        push(5, -5, 1);
        chk("s3_rdy_full", int'(cmd_rdy), 0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("s3_still_full", int'(cmd_rdy), 0);
        chk("s3_one_trigger", qx.size(), 1);
        stall = 0;
        wait_idle("s3_idle", 400);
        chk("s3_count", qx.size(), 5);
        chk_chunk("s3_c0", 0, 1, 1, 1);
        chk_chunk("s3_c1", 1, 2, -2, 0);
        chk_chunk("s3_c2", 2, 3, 3, 1);
        chk_chunk("s3_c3", 3, -4, 4, 0);
        chk_chunk("s3_c4", 4, 5, -5, 1);
        chk("s3_handshake", viol, 0);

        // Extreme values
        qclear();
        push(-128, 127, 0);
        wait_idle("s4_idle", 800);
        chk("s4_count", qx.size(), 19);
        sx = 0;
        sy = 0;
        bad = 0;
        foreach (qx[i]) begin
            sx += qx[i];
            sy += qy[i];
            if (qx[i] < -7 || qx[i] > 7 || qy[i] < -7 || qy[i] > 7) bad++;
        end
        chk("s4_sum_x", sx, -128);
        chk("s4_sum_y", sy, 127);
        chk("s4_range", bad, 0);
        chk_chunk("s4_first", 0, -7, 7, 0);
        chk_chunk("s4_last", 18, -2, 1, 0);

        // Reset during WAIT of the second chunk
        qclear();
        push(20, -3, 1);
        n = 0;
        while (qx.size() < 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        while (trigger && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("s5_in_wait", int'(trigger), 0);
        chk("s5_two_chunks", qx.size(), 2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("s5_rst_trigger", int'(trigger), 0);
        chk("s5_rst_busy", int'(busy), 0);
        chk("s5_rst_servo", int'(servo_pos), 0);
        chk("s5_rst_cmd_rdy", int'(cmd_rdy), 1);
        chk("s5_rst_px", int'(pulse_num_x), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        chk("s5_no_more", qx.size(), 2);
        chk("s5_busy", int'(busy), 0);

        // Chunking under 1/3 clk_en duty
        qclear();
        viol = 0;
        gate = 1;
        push(20, -3, 1);
        wait_idle("s6_idle", 800);
        gate = 0;
        chk("s6_count", qx.size(), 3);
        chk_chunk("s6_c0", 0, 7, -3, 1);
        chk_chunk("s6_c1", 1, 7, 0, 1);
        chk_chunk("s6_c2", 2, 6, 0, 1);
        chk("s6_handshake", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
